// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the FSM state type, the default operand width and the counter sizing helper.
package mul_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must reach WIDTH, so it needs clog2(WIDTH+1) bits.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response handshake bundle for seq_multiplier.
// The master side issues operands and accepts products; the slave side is the multiplier.
interface seq_multiplier_if
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 is_signed;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, product, busy
   );

endinterface

// File: rtl/seq_multiplier_shift_add_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// accumulator half with a carry bit, then shift {carry, accumulator} right by one.
module shift_add_step
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   mcand,
   input  logic               add_en,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (add_en ? {1'b0, mcand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
   end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, unsigned or two's-complement, one multiply in flight.
// Signed operands are reduced to magnitudes; the sign is reapplied when the result is loaded.
module seq_multiplier
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_multiplier_if.slave    bus
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t               state;
   state_t               state_nx;
   logic                 alive;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_nx;
   logic [2*WIDTH-1:0]   prod_r;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic                 neg;
   logic [CW-1:0]        cnt;
   logic                 in_fire;
   logic                 out_fire;
   logic                 last_iter;

   // alive keeps in_ready low while reset is held and for the release cycle.
   assign bus.in_ready  = alive && (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.product   = prod_r;

   assign in_fire   = bus.in_valid && bus.in_ready;
   assign out_fire  = bus.out_valid && bus.out_ready;
   assign last_iter = (cnt == CW'(WIDTH - 1));

   // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
   assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   shift_add_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc      (acc),
      .mcand    (mcand),
      .add_en   (mplier[0]),
      .acc_next (acc_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_fire)   state_nx = CALC;
         CALC:    if (last_iter) state_nx = DONE;
         DONE:    if (out_fire)  state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive  <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
         prod_r <= '0;
      end else begin
         alive <= 1'b1;
         if (in_fire) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
         end else if (state == CALC) begin
            acc    <= acc_nx;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last_iter) begin
               prod_r <= neg ? -acc_nx : acc_nx;
            end
         end
      end
   end

endmodule
